// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch controller: FSM state encoding,
// branch_type encodings, LUT/PC/offset/counter widths and target helpers.
package branch_ctrl_pkg;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned LUT_DEPTH = 16;
  localparam int unsigned LUT_IDX_W = $clog2(LUT_DEPTH);
  localparam int unsigned OFF_W     = 8;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BR_ABS    = 2'b00,  // absolute target from LUT
    BR_REL_Z  = 2'b01,  // relative, taken when zero_flag
    BR_REL_NZ = 2'b10,  // relative, taken when !zero_flag
    BR_REL    = 2'b11   // relative, unconditional
  } br_type_t;

  // Branch condition for a given type and ALU zero flag.
  function automatic logic br_taken(input br_type_t t, input logic zf);
    logic r;
    r = 1'b0;
    case (t)
      BR_ABS:    r = 1'b1;
      BR_REL_Z:  r = zf;
      BR_REL_NZ: r = ~zf;
      BR_REL:    r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // PC plus sign-extended displacement; carries out of bit 15 are dropped.
  function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0]  pc,
                                                 input logic [OFF_W-1:0] off);
    return pc + {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Branch controller bus: request/condition inputs, LUT write port, halt,
// and the registered redirect outputs.
//   master : decoder/counter side (drives requests, observes redirect)
//   slave  : branch_ctrl
interface branch_ctrl_if;
  import branch_ctrl_pkg::*;

  logic [PC_W-1:0]      PC;
  logic                 branch_req;
  logic [1:0]           branch_type;
  logic [LUT_IDX_W-1:0] lut_idx;
  logic [OFF_W-1:0]     offset;
  logic                 zero_flag;
  logic                 lut_we;
  logic [LUT_IDX_W-1:0] lut_waddr;
  logic [PC_W-1:0]      lut_wdata;
  logic                 halt_in;
  logic                 jump_en;
  logic [PC_W-1:0]      Target;
  logic                 flush;
  logic [CNT_W-1:0]     taken_cnt;

  modport master (
    output PC, branch_req, branch_type, lut_idx, offset, zero_flag,
           lut_we, lut_waddr, lut_wdata, halt_in,
    input  jump_en, Target, flush, taken_cnt
  );

  modport slave (
    input  PC, branch_req, branch_type, lut_idx, offset, zero_flag,
           lut_we, lut_waddr, lut_wdata, halt_in,
    output jump_en, Target, flush, taken_cnt
  );
endinterface

// File: rtl/branch_lut.sv
// 16x16 absolute-target lookup table: synchronous write, combinational read.
// Contents are never reset; a read of the index being written in the same
// cycle returns the old contents.
//   CLK   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational)
module branch_lut
  import branch_ctrl_pkg::*;
(
  input  logic                 CLK,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]      wdata,
  input  logic [LUT_IDX_W-1:0] raddr,
  output logic [PC_W-1:0]      rdata
);

  logic [PC_W-1:0] mem [LUT_DEPTH];

  // Write port
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: evaluates branch conditions, computes the redirect
// target (LUT or PC-relative), and sequences jump_en then flush pulses.
// Counts taken branches with a saturating counter.
//   CLK  : rising-edge clock
//   init : synchronous active-high reset (LUT contents are preserved)
//   bus  : branch_ctrl_if slave (requests in, registered redirect out)
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = '1  // saturation ceiling for taken_cnt
) (
  input  logic          CLK,
  input  logic          init,
  branch_ctrl_if.slave  bus
);

  state_t           state_q;
  logic             jump_en_q;
  logic             flush_q;
  logic [PC_W-1:0]  target_q;
  logic [CNT_W-1:0] cnt_q;

  br_type_t         btype_c;
  logic             taken_c;
  logic [PC_W-1:0]  target_c;
  logic [PC_W-1:0]  lut_rdata;

  branch_lut u_lut (
    .CLK   (CLK),
    .we    (bus.lut_we),
    .waddr (bus.lut_waddr),
    .wdata (bus.lut_wdata),
    .raddr (bus.lut_idx),
    .rdata (lut_rdata)
  );

  // Condition and target for the request presented this cycle
  always_comb begin
    btype_c  = br_type_t'(bus.branch_type);
    taken_c  = br_taken(btype_c, bus.zero_flag);
    target_c = (btype_c == BR_ABS) ? lut_rdata : rel_target(bus.PC, bus.offset);
  end

  // FSM with registered outputs; jump_en and flush are single-cycle pulses
  // that default low and are only raised on entry to REDIRECT/FLUSH.
  always_ff @(posedge CLK) begin
    if (init) begin
      state_q   <= IDLE;
      jump_en_q <= 1'b0;
      flush_q   <= 1'b0;
      target_q  <= '0;
      cnt_q     <= '0;
    end else begin
      jump_en_q <= 1'b0;
      flush_q   <= 1'b0;
      if (bus.halt_in) begin
        state_q <= HALTED;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.branch_req && taken_c) begin
              state_q   <= REDIRECT;
              jump_en_q <= 1'b1;
              target_q  <= target_c;
              if (cnt_q < CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          // Requests arriving here belong to squashed instructions
          REDIRECT: begin
            state_q <= FLUSH;
            flush_q <= 1'b1;
          end
          FLUSH: begin
            state_q <= IDLE;
          end
          HALTED: begin
            state_q <= HALTED;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.jump_en   = jump_en_q;
  assign bus.flush     = flush_q;
  assign bus.Target    = target_q;
  assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios followed by random traffic,
// checked by a scoreboard fed from a behavioural model of the branch rules.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  // Narrow ceiling so saturation is reachable in a short run
  localparam logic [15:0] SAT = 16'h0040;

  logic CLK = 1'b0;
  logic init;
  always #5 CLK = ~CLK;

  branch_ctrl_if bus ();

  branch_ctrl #(.CNT_MAX(SAT)) dut (
    .CLK  (CLK),
    .init (init),
    .bus  (bus)
  );

  typedef struct {
    int          cycle;
    bit          is_jump;
    logic [15:0] tgt;
    logic [15:0] cnt;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          jumps_seen = 0;
  int          flushes_seen = 0;

  // Reference model state
  logic [15:0] m_lut [16];
  int          m_busy = 0;
  bit          m_halted = 0;
  logic [15:0] m_tgt = 16'h0;
  logic [15:0] m_cnt = 16'h0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drop expected pulses that an init/halt at the coming edge will cancel
  task automatic drop_future();
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cycle > cyc) void'(exp_q.pop_back());
  endtask

  // Apply the branch rules to the inputs presented for the coming edge
  task automatic model_step();
    bit          taken;
    int          disp;
    logic [15:0] t;
    case (bus.branch_type)
      2'd0:    taken = 1'b1;
      2'd1:    taken = bus.zero_flag;
      2'd2:    taken = !bus.zero_flag;
      default: taken = 1'b1;
    endcase
    disp = bus.offset[7] ? int'(bus.offset) - 256 : int'(bus.offset);
    if (bus.branch_type == 2'd0) t = m_lut[bus.lut_idx];
    else t = 16'((int'(bus.PC) + disp + 65536) % 65536);

    if (init) begin
      drop_future();
      m_halted = 0; m_busy = 0; m_cnt = 16'h0; m_tgt = 16'h0;
    end else if (bus.halt_in) begin
      drop_future();
      m_halted = 1; m_busy = 0;
    end else if (!m_halted) begin
      if (m_busy > 0) m_busy--;
      else if (bus.branch_req && taken) begin
        m_tgt = t;
        if (m_cnt < SAT) m_cnt = m_cnt + 16'd1;
        exp_q.push_back('{cycle: cyc + 1, is_jump: 1'b1, tgt: t, cnt: m_cnt});
        exp_q.push_back('{cycle: cyc + 2, is_jump: 1'b0, tgt: t, cnt: m_cnt});
        m_busy = 2;
      end
    end
    if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    init = 1'b0;
    bus.branch_req = 1'b0; bus.halt_in = 1'b0; bus.lut_we = 1'b0;
    bus.branch_type = 2'd0; bus.lut_idx = 4'd0; bus.offset = 8'd0;
    bus.zero_flag = 1'b0; bus.PC = 16'h0; bus.lut_waddr = 4'd0; bus.lut_wdata = 16'h0;
  endtask

  task automatic req(input logic [1:0] typ, input logic [3:0] idx, input logic [15:0] pc,
                     input logic [7:0] off, input logic zf);
    bus.branch_req = 1'b1; bus.branch_type = typ; bus.lut_idx = idx;
    bus.PC = pc; bus.offset = off; bus.zero_flag = zf;
  endtask

  // Scoreboard monitor: pop the pulse due this cycle, flag any unexpected one
  always @(negedge CLK) begin : monitor
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cycle < cyc) begin
      e = exp_q.pop_front();
      tests++; fails++;
      $display("FAIL missed_pulse: expected %s at cycle %0d not checked", e.is_jump ? "jump_en" : "flush", e.cycle);
    end
    if (exp_q.size() > 0 && exp_q[0].cycle == cyc) begin
      e = exp_q.pop_front();
      if (e.is_jump) begin
        check("sb_jump_en", 32'(bus.jump_en), 32'd1);
        check("sb_flush_during_jump", 32'(bus.flush), 32'd0);
        check("sb_target", 32'(bus.Target), 32'(e.tgt));
        check("sb_taken_cnt", 32'(bus.taken_cnt), 32'(e.cnt));
      end else begin
        check("sb_flush", 32'(bus.flush), 32'd1);
        check("sb_jump_during_flush", 32'(bus.jump_en), 32'd0);
      end
    end else if (bus.jump_en !== 1'b0 || bus.flush !== 1'b0) begin
      tests++; fails++;
      $display("FAIL unexpected_pulse: jump_en=%b flush=%b required 0/0 (cycle %0d)", bus.jump_en, bus.flush, cyc);
    end
    if (bus.jump_en === 1'b1) jumps_seen++;
    if (bus.flush === 1'b1) flushes_seen++;
  end

  initial begin
    int j0, f0, guard;
    logic [15:0] c0, old5;

    // Reset while loading every LUT entry (writes accepted during init)
    idle_inputs();
    init = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.lut_we = 1'b1; bus.lut_waddr = 4'(i);
      bus.lut_wdata = (i == 3) ? 16'h01F0 : (i == 5) ? 16'h5555 : 16'($urandom);
      tick();
    end
    idle_inputs();
    check("rst_jump_en", 32'(bus.jump_en), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_target", 32'(bus.Target), 32'h0);
    check("rst_taken_cnt", 32'(bus.taken_cnt), 32'h0);

    // Absolute branch through LUT index 3
    req(2'd0, 4'd3, 16'h1234, 8'h00, 1'b0); tick(); bus.branch_req = 1'b0;
    check("abs_jump_en", 32'(bus.jump_en), 32'd1);
    check("abs_target", 32'(bus.Target), 32'h01F0);
    tick();
    check("abs_flush", 32'(bus.flush), 32'd1);
    check("abs_jump_cleared", 32'(bus.jump_en), 32'd0);
    tick();
    check("abs_idle_flush", 32'(bus.flush), 32'd0);

    // Relative wrap-around: 0x0002 + (-4)
    req(2'd3, 4'd0, 16'h0002, 8'hFC, 1'b0); tick(); bus.branch_req = 1'b0;
    check("wrap_target", 32'(bus.Target), 32'hFFFE);
    check("wrap_jump_en", 32'(bus.jump_en), 32'd1);
    tick();
    check("wrap_jump_once", 32'(bus.jump_en), 32'd0);
    tick();

    // Conditional on zero_flag: not taken, then taken
    req(2'd1, 4'd0, 16'h0100, 8'h10, 1'b0); tick(); bus.branch_req = 1'b0;
    check("nt_jump_en", 32'(bus.jump_en), 32'd0);
    check("nt_taken_cnt", 32'(bus.taken_cnt), 32'd2);
    check("nt_target_hold", 32'(bus.Target), 32'hFFFE);
    tick();
    check("nt_flush", 32'(bus.flush), 32'd0);
    req(2'd1, 4'd0, 16'h0100, 8'h10, 1'b1); tick(); bus.branch_req = 1'b0;
    check("tk_jump_en", 32'(bus.jump_en), 32'd1);
    check("tk_target", 32'(bus.Target), 32'h0110);
    check("tk_taken_cnt", 32'(bus.taken_cnt), 32'd3);
    tick(); tick();

    // Back-to-back taken requests: later two are squashed
    j0 = jumps_seen; f0 = flushes_seen; c0 = m_cnt;
    req(2'd3, 4'd0, 16'h2000, 8'h04, 1'b0);
    tick(); tick(); tick();
    bus.branch_req = 1'b0;
    tick();
    check("b2b_jump_pulses", 32'(jumps_seen - j0), 32'd1);
    check("b2b_flush_pulses", 32'(flushes_seen - f0), 32'd1);
    check("b2b_taken_cnt", 32'(bus.taken_cnt), 32'(c0 + 16'd1));

    // Halt wins over a same-cycle taken request
    req(2'd3, 4'd0, 16'h3000, 8'h08, 1'b0); bus.halt_in = 1'b1; tick();
    bus.halt_in = 1'b0;
    check("halt_jump_en", 32'(bus.jump_en), 32'd0);
    tick();
    check("halted_jump_en", 32'(bus.jump_en), 32'd0);
    check("halted_flush", 32'(bus.flush), 32'd0);
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd7; bus.lut_wdata = 16'hABCD; tick();
    bus.lut_we = 1'b0; bus.branch_req = 1'b0;
    init = 1'b1; tick(); init = 1'b0;
    check("init_jump_en", 32'(bus.jump_en), 32'd0);
    check("init_flush", 32'(bus.flush), 32'd0);
    check("init_target", 32'(bus.Target), 32'h0);
    check("init_taken_cnt", 32'(bus.taken_cnt), 32'h0);
    req(2'd0, 4'd3, 16'h0, 8'h0, 1'b0); tick(); bus.branch_req = 1'b0;
    check("lut_kept_idx3", 32'(bus.Target), 32'h01F0);
    tick(); tick();
    req(2'd0, 4'd7, 16'h0, 8'h0, 1'b0); tick(); bus.branch_req = 1'b0;
    check("lut_halted_write", 32'(bus.Target), 32'hABCD);
    tick(); tick();

    // Same-cycle write and lookup of index 5 returns old contents
    old5 = m_lut[5];
    req(2'd0, 4'd5, 16'h0, 8'h0, 1'b0);
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd5; bus.lut_wdata = 16'h1234; tick();
    bus.lut_we = 1'b0; bus.branch_req = 1'b0;
    check("lut_rd_old", 32'(bus.Target), 32'h5555);
    check("lut_rd_old_model", 32'(old5), 32'h5555);
    tick(); tick();
    req(2'd0, 4'd5, 16'h0, 8'h0, 1'b0); tick(); bus.branch_req = 1'b0;
    check("lut_rd_new", 32'(bus.Target), 32'h1234);
    tick(); tick();

    // Drive taken_cnt to the ceiling, then one more taken branch
    guard = 0;
    while (m_cnt != SAT && guard < 200) begin
      req(2'd3, 4'd0, 16'h4000, 8'h02, 1'b0); tick(); bus.branch_req = 1'b0; tick(); tick();
      guard++;
    end
    check("sat_reached", 32'(bus.taken_cnt), 32'(SAT));
    req(2'd2, 4'd0, 16'h4000, 8'h02, 1'b0); tick(); bus.branch_req = 1'b0;
    check("sat_jump_en", 32'(bus.jump_en), 32'd1);
    check("sat_hold", 32'(bus.taken_cnt), 32'(SAT));
    tick(); tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.branch_req  = ($urandom_range(0, 1) == 1);
      bus.branch_type = 2'($urandom_range(0, 3));
      bus.lut_idx     = 4'($urandom);
      bus.offset      = 8'($urandom);
      bus.PC          = 16'($urandom);
      bus.zero_flag   = ($urandom_range(0, 1) == 1);
      bus.lut_we      = ($urandom_range(0, 3) == 0);
      bus.lut_waddr   = 4'($urandom);
      bus.lut_wdata   = 16'($urandom);
      bus.halt_in     = ($urandom_range(0, 149) == 0);
      init            = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      tick();
    end

    idle_inputs();
    tick(); tick(); tick(); tick();
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_taken_cnt", 32'(bus.taken_cnt), 32'(m_cnt));
    check("final_target", 32'(bus.Target), 32'(m_tgt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
